// File: rtl/pattern_stream_generator_pkg.sv
// Shared colour helpers for the pattern source: pattern modes, queue control
// words and the bar colour palette.
package ColorUtilities;

  typedef enum logic [1:0] {
    PATTERN_BARS     = 2'd0,
    PATTERN_GRADIENT = 2'd1,
    PATTERN_CHECKER  = 2'd2,
    PATTERN_SOLID    = 2'd3
  } pattern_mode_t;

  localparam logic [16:0] QUEUE_FRAME_START = 17'h10000;
  localparam logic [16:0] QUEUE_ROW_START   = 17'h10001;
  localparam logic [16:0] QUEUE_FRAME_END   = 17'h1FFFF;

  // Classic SMPTE-like bars first, then extra shades for up to 16 bars.
  function automatic logic [15:0] get_rgb_color(input logic [3:0] index);
    logic [15:0] color;
    case (index)
      4'd0:    color = 16'hFFFF;
      4'd1:    color = 16'hFFE0;
      4'd2:    color = 16'h07FF;
      4'd3:    color = 16'h07E0;
      4'd4:    color = 16'hF81F;
      4'd5:    color = 16'hF800;
      4'd6:    color = 16'h001F;
      4'd7:    color = 16'h0000;
      4'd8:    color = 16'h8410;
      4'd9:    color = 16'hC618;
      4'd10:   color = 16'hFD20;
      4'd11:   color = 16'h8010;
      4'd12:   color = 16'h0410;
      4'd13:   color = 16'h8000;
      4'd14:   color = 16'h0400;
      default: color = 16'h0010;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/pattern_stream_generator_if.sv
// Pixel queue write port: the generator is the master, the queue the slave.
interface pattern_stream_generator_if;
  logic [16:0] queue_data;
  logic        queue_wr_en;
  logic        queue_wr_clk;
  logic        queue_full;

  modport master (output queue_data, queue_wr_en, queue_wr_clk, input queue_full);
  modport slave  (input queue_data, queue_wr_en, queue_wr_clk, output queue_full);
endinterface

// File: rtl/pattern_stream_generator_pixel.sv
// Combinational RGB565 pixel colour for one effective column and row; kept
// separate so the pattern logic can be exercised on its own.
module pattern_pixel_source
  import ColorUtilities::*;
#(
  parameter int FRAME_WIDTH    = 640,
  parameter int NUM_COLOR_BARS = 10,
  parameter int CHECKER_LOG2   = 4
) (
  input  logic [10:0]   i_x,
  input  logic [10:0]   i_row,
  input  pattern_mode_t i_mode,
  input  logic [15:0]   i_solidColor,
  output logic [15:0]   o_rgb
);

  localparam int BAR_WIDTH = FRAME_WIDTH / NUM_COLOR_BARS;

  logic [3:0] w_barIndex;
  logic       w_checkerOn;
  logic       w_unusedRowBits;

  // Bar index counts the bar boundaries at or left of x; the last bar absorbs the remainder.
  always_comb begin
    w_barIndex = 4'd0;
    for (int k = 1; k < NUM_COLOR_BARS; k++) begin
      if (int'(i_x) >= k * BAR_WIDTH) w_barIndex = 4'(k);
    end
  end

  assign w_checkerOn     = i_x[CHECKER_LOG2] ^ i_row[CHECKER_LOG2];
  assign w_unusedRowBits = ^i_row;

  always_comb begin
    o_rgb = 16'h0000;
    case (i_mode)
      PATTERN_BARS:     o_rgb = get_rgb_color(w_barIndex);
      PATTERN_GRADIENT: o_rgb = {i_x[4:0], i_x[5:0], i_x[4:0]};
      PATTERN_CHECKER:  o_rgb = w_checkerOn ? 16'hFFFF : 16'h0000;
      default:          o_rgb = i_solidColor;
    endcase
  end

endmodule

// File: rtl/pattern_stream_generator.sv
// Test-pattern frame source feeding the 17-bit pixel queue, one word per
// non-stalled cycle, with per-frame scrolling and a frame counter.
module pattern_stream_generator
  import ColorUtilities::*;
#(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int NUM_COLOR_BARS = 10,
  parameter int CHECKER_LOG2   = 4,
  parameter int SCROLL_STEP    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [15:0]                solid_color,
  pattern_stream_generator_if.master q,
  output logic [15:0]                frame_count,
  output logic                       busy
);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_START,
    ROW_START,
    PIXELS,
    FRAME_END
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [10:0]   r_col;
  logic [10:0]   r_row;
  logic [10:0]   r_offset;
  logic [10:0]   r_offsetLatched;
  pattern_mode_t r_mode;
  logic [15:0]   r_solid;
  logic [15:0]   r_frameCount;
  logic [16:0]   r_queueData;
  logic          r_queueWrEn;

  logic          w_lastCol;
  logic          w_lastRow;
  logic [11:0]   w_xSum;
  logic [10:0]   w_x;
  logic [11:0]   w_offsetSum;
  logic [10:0]   w_nextOffset;
  logic [15:0]   w_pixel;
  logic          w_launch;
  logic [16:0]   w_word;

  assign w_lastCol = (r_col == 11'(FRAME_WIDTH - 1));
  assign w_lastRow = (r_row == 11'(FRAME_HEIGHT - 1));

  // Both column and offset are below FRAME_WIDTH, so one subtract wraps the sum.
  assign w_xSum       = {1'b0, r_col} + {1'b0, r_offsetLatched};
  assign w_x          = (w_xSum >= 12'(FRAME_WIDTH)) ? 11'(w_xSum - 12'(FRAME_WIDTH)) : w_xSum[10:0];
  assign w_offsetSum  = {1'b0, r_offset} + 12'(SCROLL_STEP);
  assign w_nextOffset = (w_offsetSum >= 12'(FRAME_WIDTH)) ? 11'(w_offsetSum - 12'(FRAME_WIDTH)) : w_offsetSum[10:0];

  pattern_pixel_source #(
    .FRAME_WIDTH   (FRAME_WIDTH),
    .NUM_COLOR_BARS(NUM_COLOR_BARS),
    .CHECKER_LOG2  (CHECKER_LOG2)
  ) u_pixelSource (
    .i_x         (w_x),
    .i_row       (r_row),
    .i_mode      (r_mode),
    .i_solidColor(r_solid),
    .o_rgb       (w_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:        if (enable) w_nextState = FRAME_START;
      FRAME_START: if (!q.queue_full) w_nextState = ROW_START;
      ROW_START:   if (!q.queue_full) w_nextState = PIXELS;
      PIXELS: begin
        if (!q.queue_full && w_lastCol) w_nextState = w_lastRow ? FRAME_END : ROW_START;
      end
      FRAME_END:   if (!q.queue_full) w_nextState = IDLE;
      default:     w_nextState = IDLE;
    endcase
  end

  // A word launches from every active state unless the queue reports almost-full.
  always_comb begin
    w_launch = (r_state != IDLE) && !q.queue_full;
    w_word   = 17'h00000;
    case (r_state)
      FRAME_START: w_word = QUEUE_FRAME_START;
      ROW_START:   w_word = QUEUE_ROW_START;
      PIXELS:      w_word = {1'b0, w_pixel};
      FRAME_END:   w_word = QUEUE_FRAME_END;
      default:     w_word = 17'h00000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col           <= '0;
      r_row           <= '0;
      r_offset        <= '0;
      r_offsetLatched <= '0;
      r_mode          <= PATTERN_BARS;
      r_solid         <= '0;
      r_frameCount    <= '0;
      r_queueData     <= '0;
      r_queueWrEn     <= 1'b0;
    end else begin
      r_queueWrEn <= w_launch;
      if (w_launch) begin
        r_queueData <= w_word;
        case (r_state)
          FRAME_START: begin
            r_mode          <= pattern_mode_t'(mode);
            r_solid         <= solid_color;
            r_offsetLatched <= r_offset;
            r_col           <= '0;
            r_row           <= '0;
          end
          PIXELS: begin
            if (w_lastCol) begin
              r_col <= '0;
              if (!w_lastRow) r_row <= r_row + 11'd1;
            end else begin
              r_col <= r_col + 11'd1;
            end
          end
          FRAME_END: begin
            r_frameCount <= r_frameCount + 16'd1;
            r_offset     <= w_nextOffset;
          end
          default: ;
        endcase
      end
    end
  end

  assign q.queue_data   = r_queueData;
  assign q.queue_wr_en  = r_queueWrEn;
  assign q.queue_wr_clk = clk;
  assign frame_count    = r_frameCount;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_pattern_stream_generator.sv
// Self-checking bench: compares the captured queue stream against a frame
// model built from the pattern rules, with random stalls and colours.
module tb_pattern_stream_generator;

  localparam int W         = 10;
  localparam int H         = 3;
  localparam int NB        = 3;
  localparam int CL        = 1;
  localparam int SS        = 3;
  localparam int BW        = W / NB;
  localparam int FRAME_LEN = 2 + H * (W + 1);
  localparam int BUDGET    = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] solidColor;
  logic [15:0] frameCount;
  logic        busy;

  pattern_stream_generator_if qIf ();

  pattern_stream_generator #(
    .FRAME_WIDTH   (W),
    .FRAME_HEIGHT  (H),
    .NUM_COLOR_BARS(NB),
    .CHECKER_LOG2  (CL),
    .SCROLL_STEP   (SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .solid_color(solidColor),
    .q          (qIf.master),
    .frame_count(frameCount),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycleIdx = 0;
  int          endsSeen = 0;
  int          modelOffset = 0;
  int          modelFrames = 0;
  bit          lastFull = 1'b0;
  logic [16:0] rxQ[$];
  int          rxCycle[$];
  logic [16:0] expQ[$];
  logic [15:0] barColors[16] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800,
                                 16'h001F, 16'h0000, 16'h8410, 16'hC618, 16'hFD20, 16'h8010,
                                 16'h0410, 16'h8000, 16'h0400, 16'h0010};
  int          barMap[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2};
  int          scrollXs[5] = '{0, 3, 6, 9, 2};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive the next queue_full.
  task automatic applyStimulus(input bit stall);
    @(negedge clk);
    cycleIdx++;
    if (lastFull) checkOutput("noWriteAfterFull", 32'(qIf.queue_wr_en), 32'd0);
    if (qIf.queue_wr_en) begin
      rxQ.push_back(qIf.queue_data);
      rxCycle.push_back(cycleIdx);
      if (qIf.queue_data == 17'h1FFFF) endsSeen++;
    end
    lastFull = stall ? 1'($urandom_range(0, 1)) : 1'b0;
    qIf.queue_full = lastFull;
  endtask

  function automatic logic [15:0] modelPixel(input int m, input int col, input int row,
                                             input int off, input logic [15:0] solid);
    int x;
    int idx;
    x = (col + off) % W;
    case (m)
      0: begin
        idx = x / BW;
        if (idx > NB - 1) idx = NB - 1;
        return barColors[idx];
      end
      1: return 16'(((x % 32) << 11) | ((x % 64) << 5) | (x % 32));
      2: return ((((x >> CL) & 1) ^ ((row >> CL) & 1)) != 0) ? 16'hFFFF : 16'h0000;
      default: return solid;
    endcase
  endfunction

  task automatic buildFrame(input int m, input logic [15:0] solid);
    expQ.push_back(17'h10000);
    for (int r = 0; r < H; r++) begin
      expQ.push_back(17'h10001);
      for (int c = 0; c < W; c++) expQ.push_back({1'b0, modelPixel(m, c, r, modelOffset, solid)});
    end
    expQ.push_back(17'h1FFFF);
    modelOffset = (modelOffset + SS) % W;
    modelFrames++;
  endtask

  task automatic clearStreams();
    rxQ.delete();
    rxCycle.delete();
    expQ.delete();
    endsSeen = 0;
  endtask

  task automatic waitFrames(input int n, input bit stall);
    for (int k = 0; k < BUDGET && endsSeen < n; k++) applyStimulus(stall);
    checkOutput("framesDone", 32'(endsSeen), 32'(n));
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, "Len"}, 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("%s[%0d]", tag, i), (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hxxxx_xxxx, 32'(expQ[i]));
  endtask

  task automatic pulseEnable();
    enable = 1'b1;
    applyStimulus(1'b0);
    enable = 1'b0;
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    enable = 1'b0;
    mode = 2'd0;
    solidColor = 16'h0000;
    qIf.queue_full = 1'b0;
    repeat (3) applyStimulus(1'b0);
    checkOutput("rstWrEn", 32'(qIf.queue_wr_en), 32'd0);
    checkOutput("rstData", 32'(qIf.queue_data), 32'd0);
    checkOutput("rstFrameCount", 32'(frameCount), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("wrClk", 32'(qIf.queue_wr_clk), 32'(clk));
    reset = 1'b0;
    applyStimulus(1'b0);

    $display("[TB] colour bars, offset 0");
    clearStreams();
    mode = 2'd0;
    buildFrame(0, 16'h0000);
    pulseEnable();
    waitFrames(1, 1'b0);
    compareStream("bars");
    for (int c = 0; c < W; c++)
      checkOutput($sformatf("barCol%0d", c), (2 + c < rxQ.size()) ? 32'(rxQ[2 + c]) : 32'hxxxx_xxxx,
                  32'({1'b0, barColors[barMap[c]]}));
    checkOutput("barsFrameCount", 32'(frameCount), 32'(modelFrames));

    $display("[TB] gradient, latency and back-to-back words");
    clearStreams();
    mode = 2'd1;
    buildFrame(1, 16'h0000);
    c0 = cycleIdx;
    pulseEnable();
    checkOutput("busyRunning", 32'(busy), 32'd1);
    waitFrames(1, 1'b0);
    compareStream("gradient");
    checkOutput("firstWordLatency", (rxCycle.size() > 0) ? 32'(rxCycle[0] - c0) : 32'hFFFF_FFFF, 32'd2);
    checkOutput("noGaps", (rxCycle.size() > 0) ? 32'(rxCycle[rxCycle.size() - 1] - rxCycle[0]) : 32'hFFFF_FFFF,
                32'(FRAME_LEN - 1));
    applyStimulus(1'b0);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("gradFrameCount", 32'(frameCount), 32'(modelFrames));

    $display("[TB] checker with random stalls");
    clearStreams();
    mode = 2'd2;
    buildFrame(2, 16'h0000);
    pulseEnable();
    waitFrames(1, 1'b1);
    compareStream("checkerStall");

    $display("[TB] solid colour with random stalls");
    clearStreams();
    mode = 2'd3;
    solidColor = 16'($urandom);
    buildFrame(3, solidColor);
    pulseEnable();
    waitFrames(1, 1'b1);
    compareStream("solidStall");
    checkOutput("solidFrameCount", 32'(frameCount), 32'(modelFrames));

    $display("[TB] mode change and enable drop mid-frame");
    clearStreams();
    applyStimulus(1'b0);
    mode = 2'd2;
    buildFrame(2, 16'h0000);
    enable = 1'b1;
    repeat (6) applyStimulus(1'b0);
    mode = 2'd3;
    solidColor = 16'($urandom);
    enable = 1'b0;
    waitFrames(1, 1'b0);
    repeat (30) applyStimulus(1'b0);
    compareStream("modeLatch");
    checkOutput("noRestart", 32'(endsSeen), 32'd1);

    $display("[TB] reset in the middle of a row");
    clearStreams();
    mode = 2'd1;
    pulseEnable();
    repeat (6) applyStimulus(1'b0);
    reset = 1'b1;
    applyStimulus(1'b0);
    checkOutput("midRstWrEn", 32'(qIf.queue_wr_en), 32'd0);
    checkOutput("midRstData", 32'(qIf.queue_data), 32'd0);
    checkOutput("midRstFrameCount", 32'(frameCount), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstNoEnd", 32'(endsSeen), 32'd0);
    reset = 1'b0;
    modelOffset = 0;
    modelFrames = 0;

    $display("[TB] scrolling with enable held high");
    clearStreams();
    mode = 2'd1;
    for (int f = 0; f < 5; f++) buildFrame(1, 16'h0000);
    enable = 1'b1;
    waitFrames(5, 1'b0);
    enable = 1'b0;
    repeat (5) applyStimulus(1'b0);
    compareStream("scroll");
    for (int f = 0; f < 5; f++) begin
      int idx;
      idx = f * FRAME_LEN + 2;
      checkOutput($sformatf("scrollFirstPix%0d", f), (idx < rxQ.size()) ? 32'(rxQ[idx]) : 32'hxxxx_xxxx,
                  32'({1'b0, modelPixel(1, scrollXs[f], 0, 0, 16'h0000)}));
    end
    for (int f = 0; f < 4; f++) begin
      int e;
      e = (f + 1) * FRAME_LEN - 1;
      checkOutput($sformatf("idleGap%0d", f), (e + 1 < rxCycle.size()) ? 32'(rxCycle[e + 1] - rxCycle[e]) : 32'hFFFF_FFFF,
                  32'd2);
    end
    checkOutput("scrollFrameCount", 32'(frameCount), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_stream_generator.md
# pattern_stream_generator

Parametrised, multi-mode test-pattern source that streams complete frames into the 17-bit pixel queue in front of the framebuffer/LCD path. It replaces the fixed colour-bar debug generator. It adds selectable patterns, a per-frame scrolling offset, a frame counter, clean enable/stop semantics and strict one-word-per-cycle queue flow control. It sits where the camera capture path would feed the queue, so display logic can be brought up with no sensor attached.

## Interface
- FRAME_WIDTH, 640: pixels per row, 2..2047.
- FRAME_HEIGHT, 480: rows per frame, 1..2047.
- NUM_COLOR_BARS, 10: bars in mode 0, 1..16.
- CHECKER_LOG2, 4: checker square side is 2**CHECKER_LOG2 pixels.
- SCROLL_STEP, 0: columns added to the scroll offset per frame; 0 means static. Must be < FRAME_WIDTH.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled in IDLE.
- mode  in  2  pattern select: 0 bars, 1 gradient, 2 checker, 3 solid.
- solid_color  in  16  RGB565 value used in mode 3.
- queue_full  in  1  queue almost-full; must assert with at least one free slot left.
- queue_data  out  17  bit16=1 marks a control word, bit16=0 marks a pixel (RGB565 in [15:0]).
- queue_wr_en  out  1  one word is written on each rising edge where this is 1.
- queue_wr_clk  out  1  equal to clk.
- frame_count  out  16  number of frames completed; wraps at 2**16.
- busy  out  1  high while in any state other than IDLE.

## Operation
- Reset values: queue_data=0, queue_wr_en=0, frame_count=0, busy=0, scroll offset=0, state IDLE.
- Frame word sequence: 17'h10000, then FRAME_HEIGHT × (17'h10001 followed by FRAME_WIDTH pixels), then 17'h1FFFF.
- A frame contains 2 + FRAME_HEIGHT·(FRAME_WIDTH+1) words.
- States and transitions:
  - IDLE → FRAME_START when enable=1.
  - FRAME_START → ROW_START.
  - ROW_START → PIXELS.
  - PIXELS → ROW_START after the last column, or → FRAME_END after the last column of the last row.
  - FRAME_END → IDLE.
- Each of FRAME_START, ROW_START, PIXELS and FRAME_END emits one word per cycle in which queue_full=0.
- When queue_full=1, the state, counters and the next word are all held, and queue_wr_en=0 on the next edge.
- mode, solid_color and the scroll offset are latched in FRAME_START and are constant for the whole frame.
- Dropping enable mid-frame has no effect on the current frame. The frame completes, including 1FFFF, and the block then stays in IDLE.
- FRAME_END: frame_count += 1 and offset = offset + SCROLL_STEP. If the result is ≥ FRAME_WIDTH, subtract FRAME_WIDTH (single conditional subtract).
- Effective column: x = col + offset, with the same conditional-subtract wrap. This keeps x in 0..FRAME_WIDTH-1.
- Mode 0: bar width is bw = FRAME_WIDTH / NUM_COLOR_BARS. Bar index is min(x / bw, NUM_COLOR_BARS-1), so the last bar absorbs the remainder. Colour is get_rgb_color(index).
- Mode 0 must use a bar-boundary comparator chain or an incremental bar counter, never a divider.
- Mode 1: pixel = {x[4:0], x[5:0], x[4:0]}.
- Mode 2: pixel = 16'hFFFF if x[CHECKER_LOG2] ^ row[CHECKER_LOG2], else 16'h0000.
- Mode 3: pixel = latched solid_color.
- Reset mid-frame: all outputs return to reset values on the reset edge. No 1FFFF is emitted and the partial frame is abandoned.

## Timing
- Pixel path: counters feed the colour logic, which feeds the registered queue_data, giving 1 cycle of latency. queue_data and queue_wr_en are always registered.
- enable sampled high in IDLE at edge N: 17'h10000 is on queue_data with queue_wr_en=1 after edge N+1.
- With queue_full held 0, every word goes out on consecutive edges with no gaps.
- Between 1FFFF and the next 10000 there is exactly 1 idle cycle (queue_wr_en=0), which is the IDLE cycle.
- Frame period with no stalls: 3 + FRAME_HEIGHT·(FRAME_WIDTH+1) cycles.
- queue_full is sampled on the same edge that would launch a word. That word is delayed with no loss and no duplication.
- frame_count updates on the edge that launches 1FFFF.

## Structure
- Shared package ColorUtilities gains:
  - pattern_mode_t (PATTERN_BARS, PATTERN_GRADIENT, PATTERN_CHECKER, PATTERN_SOLID);
  - constants QUEUE_FRAME_START=17'h10000, QUEUE_ROW_START=17'h10001, QUEUE_FRAME_END=17'h1FFFF.
- The state enum is local to the module.
- One sub-module, pattern_pixel_source: purely combinational; inputs x, row, mode, solid_color; output RGB565. It holds the bar and checker logic so it can be unit-tested on its own.
- No RAM; counters are 11 bits wide.

## Test plan
- FRAME_WIDTH=8, FRAME_HEIGHT=2, mode 1, queue_full=0, enable pulsed once → words 10000, 10001, 8 pixels for x=0..7, 10001, 8 pixels, 1FFFF. That is 20 consecutive wr_en cycles; then busy=0 and frame_count=1.
- FRAME_WIDTH=10, NUM_COLOR_BARS=3, mode 0 → bw=3; columns 0-2 use colour 0, 3-5 colour 1, 6-9 colour 2.
- queue_full toggled randomly at 50% over a full frame → the received word stream is identical to the stall-free run, and wr_en is never 1 in the cycle after full was sampled 1.
- SCROLL_STEP=3, FRAME_WIDTH=8, mode 1, enable held high → first pixel of frames 0..3 is x=0, 3, 6, 1 (wrap); frame_count=4 after four frames.
- mode changed and enable dropped mid-frame → the current frame keeps its latched mode and ends with 1FFFF; no further 10000 appears.
- reset asserted for 1 cycle mid-row → on the next edge queue_wr_en=0, queue_data=0, frame_count=0; the next frame starts again with 10000.
